// File: rtl/paper_pkg.sv
// Shared definitions for the paper processor: opcodes, sequencer states and
// the saturating counter helper used for the retired-instruction count.
package paper_pkg;

    localparam int ROM_AW = 2;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OPER  = 3'd3,
        HALT  = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/paper_seq_ctrl.sv
// Sequencer for the paper processor: fetches 2-bit words from the external
// ROM, executes INC/JNO/HLT and owns pc, acc, ovf, illegal and retired.
module paper_seq_ctrl
    import paper_pkg::*;
#(
    parameter int ACC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ROM_AW-1:0]    instr_addr,
    input  logic [1:0]           instr_data,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 ovf,
    output logic [ROM_AW-1:0]    pc,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal,
    output logic [7:0]           retired
);

    state_t             state, state_nxt;
    logic [1:0]         ir;
    logic [ACC_WIDTH:0] acc_sum;

    assign acc_sum = {1'b0, acc} + {{ACC_WIDTH{1'b0}}, 1'b1};
    assign busy    = (state == FETCH) || (state == EXEC) || (state == OPER);
    assign halted  = (state == HALT);

    always_comb begin
        state_nxt  = state;
        instr_addr = pc;
        case (state)
            IDLE, HALT: if (start) state_nxt = FETCH;
            FETCH:      state_nxt = EXEC;
            EXEC: begin
                case (ir)
                    OP_INC:  state_nxt = FETCH;
                    OP_JNO:  state_nxt = OPER;
                    default: state_nxt = HALT;
                endcase
            end
            OPER: begin
                // JNO operand lives in the word after the opcode, wrapping at the top.
                instr_addr = pc + 2'd1;
                state_nxt  = FETCH;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            illegal <= 1'b0;
            retired <= '0;
            ir      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        pc      <= '0;
                        acc     <= '0;
                        ovf     <= 1'b0;
                        illegal <= 1'b0;
                        retired <= '0;
                    end
                end
                FETCH: ir <= instr_data;
                EXEC: begin
                    case (ir)
                        OP_INC: begin
                            {ovf, acc} <= acc_sum;
                            pc         <= pc + 2'd1;
                            retired    <= sat_inc8(retired);
                        end
                        OP_HLT: retired <= sat_inc8(retired);
                        OP_ILL: begin
                            illegal <= 1'b1;
                            retired <= sat_inc8(retired);
                        end
                        default: ;
                    endcase
                end
                OPER: begin
                    pc      <= ovf ? pc + 2'd2 : instr_data;
                    retired <= sat_inc8(retired);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/paper_seq_ctrl.md
# paper_seq_ctrl

Sequencing controller for the paper processor. Fetches 2-bit instruction words from the 4-word instruction ROM (`twoBitRam`, combinational read), decodes INC/JNO/HLT, and maintains the program counter, accumulator and overflow flag. It sits between the top level (start/status) and the ROM address/data pins, and owns all processor architectural state.

## Interface
- `ACC_WIDTH`, default 4: accumulator width in bits, at least 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: level sampled in IDLE or HALT; begins execution from address 0.
- `instr_addr` output 2: ROM address; combinational from state and pc.
- `instr_data` input 2: ROM read data, valid in the same cycle as `instr_addr`.
- `acc` output ACC_WIDTH: accumulator.
- `ovf` output 1: carry out of the last INC.
- `pc` output 2: program counter.
- `busy` output 1: high in FETCH, EXEC and OPER.
- `halted` output 1: high in HALT.
- `illegal` output 1: set when opcode 11 is executed; cleared on restart or reset.
- `retired` output 8: count of executed instructions, saturating at 255.

## Operation
- Opcodes: INC=00, JNO=01 (the next word is the target address), HLT=10, 11 is illegal.
- Reset (async, immediate): state=IDLE, pc=0, acc=0, ovf=0, illegal=0, retired=0, ir=0.
- IDLE: `start`=1 moves to FETCH. pc, acc, ovf, illegal and retired are cleared on the same edge.
- FETCH: instr_addr=pc. ir<=instr_data. Next state is EXEC.
- EXEC, decoded from ir:
  - INC: {ovf,acc}<=acc+1 (ACC_WIDTH+1-bit sum; acc wraps to 0 and ovf=1 on all-ones). pc<=pc+1 mod 4. Next state FETCH. retired++.
  - JNO: next state OPER. No state update.
  - HLT: next state HALT. retired++.
  - 11: illegal<=1. Next state HALT. retired++.
- OPER: instr_addr=pc+1 mod 4.
  - If ovf=0: pc<=instr_data.
  - Else: pc<=pc+2 mod 4.
  - ovf is unchanged. retired++. Next state FETCH.
- HALT: holds all state. `start`=1 restarts exactly as from IDLE.
- `start` in busy states is ignored.
- Defaults: instr_addr=pc in IDLE, EXEC and HALT.
- pc wraps mod 4 everywhere. A JNO at address 3 reads its operand from address 0.
- retired saturates: it stays at 255 and does not wrap.

## Timing
- All state updates occur on the rising edge of clk, except reset.
- Cycles per instruction: INC=2 (FETCH+EXEC), JNO=3 (FETCH+EXEC+OPER), HLT=2 to `halted`.
- `halted` asserts on the edge that enters HALT, 2 cycles after HLT's FETCH begins.
- Outputs are registered except `instr_addr`, `busy` and `halted`, which decode from state.
- Reset asserted mid-instruction aborts it with no partial update surviving. After release the block is in IDLE and needs a fresh `start`.
- `start` held high through HALT restarts on every HALT entry. Top level pulses it for one cycle.

## Structure
- Shared package `paper_pkg`:
  - opcode constants OP_INC, OP_JNO, OP_HLT, OP_ILL;
  - state enum IDLE, FETCH, EXEC, OPER, HALT (3-bit encoding);
  - ROM address width constant 2.
- Single module with no sub-module: a one-process state register plus combinational next-state/address decode.
- The ROM is instantiated beside it at top level, not inside it.

## Test plan
- ROM {00,01,00,10}, ACC_WIDTH=4, start pulse:
  - 16 INCs and 15 taken JNOs, then a not-taken JNO and HLT;
  - halted=1 exactly 82 cycles after the start-sampling edge;
  - final acc=0, ovf=1, pc=3, retired=33.
- ROM {00,00,00,10}: halted after 8 cycles; acc=3, ovf=0, retired=4, pc=3.
- ROM {11,xx,xx,xx}: halted after 2 cycles; illegal=1, retired=1, acc=0.
- ROM {00,01,00,10}, rst asserted asynchronously mid-OPER at cycle 13:
  - outputs are immediately pc=0, acc=0, busy=0;
  - after release, no activity until start.
- After halt from scenario 2, pulse start again: identical 8-cycle run with illegal=0. A start pulse asserted while busy changes nothing.
- ROM {01,11,00,10} (JNO at 0 with ovf=0): pc=3 after 3 cycles, then HLT; halted at cycle 5, retired=2.
